// File: rtl/ovi_issue_driver.sv
// ovi_issue_driver: streams a preloaded vector program to the vector core over
// the OVI issue interface. Up to MAX_OUTSTANDING issued-but-uncompleted
// instructions may be in flight. The block also serves core load/store
// petitions from a small data memory with a fixed response latency.
module ovi_issue_driver #(
  parameter int IMEM_DEPTH      = 64,
  parameter int INSTR_W         = 32,
  parameter int VL_W            = 15,
  parameter int SEW_W           = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DMEM_WORDS      = 16,
  parameter int DATA_W          = 32,
  parameter int MEM_LAT         = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PROG_WE,
  input  logic [$clog2(IMEM_DEPTH)-1:0] PROG_ADDR,
  input  logic [INSTR_W-1:0]            PROG_DATA,
  input  logic [VL_W-1:0]               CFG_VL,
  input  logic [SEW_W-1:0]              CFG_SEW,
  input  logic                          START,
  input  logic                          CORE_HALT,
  output logic                          ISSUE_VALID,
  output logic [INSTR_W-1:0]            ISSUE_INSTR,
  output logic [4:0]                    ISSUE_OPND,
  output logic [VL_W-1:0]               ISSUE_VL,
  output logic [SEW_W-1:0]              ISSUE_SEW,
  output logic                          ISSUE_WB,
  input  logic                          COMPLETED_VALID,
  input  logic                          LS_LOAD_VALID,
  input  logic                          LS_STORE_VALID,
  input  logic [$clog2(DMEM_WORDS)-1:0] LS_ADDR,
  input  logic [DATA_W-1:0]             LS_STORE_DATA,
  output logic                          LS_MEM_READY,
  output logic                          LS_LOAD_DATA_VALID,
  output logic [DATA_W-1:0]             LS_LOAD_DATA,
  output logic [3:0]                    OUTSTANDING,
  output logic                          DONE,
  output logic                          PROTO_ERR
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [3:0]    MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [IA-1:0] PC_LAST = IA'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  dmem [DMEM_WORDS];

  state_t             state;
  logic [IA-1:0]      pc;
  logic [3:0]         outstanding;
  logic [VL_W-1:0]    vl_q;
  logic [SEW_W-1:0]   sew_q;
  logic               done_q;
  logic               proto_err_q;

  logic               ready_q;
  logic [LW-1:0]      lat_cnt;
  logic               pend_load;
  logic [DATA_W-1:0]  rd_q;
  logic               load_valid_q;
  logic [DATA_W-1:0]  load_data_q;

  // Issue side: everything the core sees is a direct decode of IMEM[PC].
  logic [INSTR_W-1:0] cur_instr;
  logic               instr_is_end;
  logic               issue_fire;
  logic               complete_ok;
  logic               complete_err;

  assign cur_instr    = imem[pc];
  assign instr_is_end = (cur_instr == '1);
  assign issue_fire   = (state == S_ISSUE) && !CORE_HALT &&
                        (outstanding < MAX_OUT) && !instr_is_end;
  assign complete_ok  = COMPLETED_VALID && (outstanding != 4'd0);
  assign complete_err = COMPLETED_VALID && (outstanding == 4'd0);

  assign ISSUE_VALID = issue_fire;
  assign ISSUE_INSTR = cur_instr;
  assign ISSUE_OPND  = cur_instr[19:15];
  assign ISSUE_VL    = vl_q;
  assign ISSUE_SEW   = sew_q;
  assign ISSUE_WB    = (cur_instr[14:12] == 3'b010) &&
                       (cur_instr[6:0] == 7'b1010111) &&
                       (cur_instr[31:26] != 6'd0);

  // Data side: a petition is taken only when idle and unambiguous.
  logic ls_any;
  logic ls_both;
  logic ls_accept;
  logic ls_err;

  assign ls_any    = LS_LOAD_VALID || LS_STORE_VALID;
  assign ls_both   = LS_LOAD_VALID && LS_STORE_VALID;
  assign ls_accept = ready_q && ls_any && !ls_both;
  assign ls_err    = ls_any && (!ready_q || ls_both);

  assign LS_MEM_READY       = ready_q;
  assign LS_LOAD_DATA_VALID = load_valid_q;
  assign LS_LOAD_DATA       = load_data_q;
  assign OUTSTANDING        = outstanding;
  assign DONE               = done_q;
  assign PROTO_ERR          = proto_err_q;

  // Program memory is writable only while idle.
  // NOTE: memories carry no reset; a program image must survive RST.
  always_ff @(posedge CLK) begin
    if (!RST && (state == S_IDLE) && PROG_WE) begin
      imem[PROG_ADDR] <= PROG_DATA;
    end
  end

  // Data memory store port; writes land in the acceptance cycle.
  always_ff @(posedge CLK) begin
    if (!RST && ls_accept && LS_STORE_VALID) begin
      dmem[LS_ADDR] <= LS_STORE_DATA;
    end
  end

  // Issue sequencer: program counter, outstanding count and latched config.
  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      pc          <= '0;
      outstanding <= 4'd0;
      vl_q        <= '0;
      sew_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      unique case ({issue_fire, complete_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      unique case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            vl_q   <= CFG_VL;
            sew_q  <= CFG_SEW;
            pc     <= '0;
            done_q <= 1'b0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_is_end) begin
            state <= S_DRAIN;
          end else if (issue_fire) begin
            pc <= pc + IA'(1);
            if (pc == PC_LAST) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (outstanding == 4'd0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Load/store latency engine and sticky protocol-error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ready_q      <= 1'b1;
      lat_cnt      <= '0;
      pend_load    <= 1'b0;
      rd_q         <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      if (ls_err || complete_err) proto_err_q <= 1'b1;

      if (ls_accept) begin
        ready_q   <= 1'b0;
        lat_cnt   <= LW'(MEM_LAT - 1);
        pend_load <= LS_LOAD_VALID;
        rd_q      <= dmem[LS_ADDR];
      end else if (!ready_q) begin
        if (lat_cnt == LW'(1)) begin
          ready_q   <= 1'b1;
          lat_cnt   <= '0;
          pend_load <= 1'b0;
          if (pend_load) begin
            load_valid_q <= 1'b1;
            load_data_q  <= rd_q;
          end
        end else begin
          lat_cnt <= lat_cnt - LW'(1);
        end
      end
    end
  end

endmodule
